// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: angle table, gain, quarter-turn constant, mode and state codes.
package cordic_pkg;

    typedef enum logic {
        MODE_ROT = 1'b0,
        MODE_VEC = 1'b1
    } mode_e;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_ITER = 3'd2;
    localparam logic [2:0] S_GAIN = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // Elaboration-time constants are built in Q4.60, then rounded to the datapath scale.
    localparam int unsigned CF      = 60;
    localparam int unsigned KF      = 32;
    localparam logic [63:0] PI_2_CF = 64'h1921_FB54_442D_1847;
    localparam logic [63:0] PI_4_CF = 64'h0C90_FDAA_2216_8C23;

    function automatic logic [63:0] cf_round(logic [63:0] v, int unsigned fb);
        return (v + (64'd1 << (CF - fb - 1))) >> (CF - fb);
    endfunction

    function automatic logic [63:0] pi_2_fx(int unsigned fb);
        return cf_round(PI_2_CF, fb);
    endfunction

    // atan(2^-i) by its odd power series; i=0 uses the exact pi/4 constant.
    function automatic logic [63:0] atan_fx(int unsigned fb, int unsigned i);
        logic [63:0] acc;
        int unsigned sh;
        if (i == 0) return cf_round(PI_4_CF, fb);
        acc = '0;
        for (int unsigned k = 0; k < 32; k++) begin
            sh = i * (2 * k + 1);
            if (sh <= CF) begin
                if (k % 2 == 0) acc = acc + ((64'd1 << (CF - sh)) / 64'(2 * k + 1));
                else            acc = acc - ((64'd1 << (CF - sh)) / 64'(2 * k + 1));
            end
        end
        return cf_round(acc, fb);
    endfunction

    // K = 1/sqrt(prod(1+4^-i)), returned as an unsigned Q0.KF fraction.
    function automatic logic [KF-1:0] k_gain(int unsigned iter);
        logic [63:0] p;
        logic [63:0] n;
        logic [63:0] res;
        logic [63:0] bit_v;
        p = 64'd1 << CF;
        for (int unsigned i = 0; i < iter; i++) p = p + (p >> (2 * i));
        n     = p;
        res   = '0;
        bit_v = 64'd1 << 62;
        for (int unsigned j = 0; j < 32; j++) begin
            if (n >= res + bit_v) begin
                n   = n - (res + bit_v);
                res = (res >> 1) + bit_v;
            end else begin
                res = res >> 1;
            end
            bit_v = bit_v >> 2;
        end
        return KF'((64'd1 << (CF / 2 + KF)) / res);
    endfunction

endpackage

// File: rtl/cordic_sm_conv.sv
// Sign-magnitude <-> two's-complement converter; the towards-sign-magnitude direction saturates.
module cordic_sm_conv #(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned OUT_W = 34,
    parameter bit          TO_SM = 1'b0
) (
    input  logic [IN_W-1:0]  a_i,
    output logic [OUT_W-1:0] b_o,
    output logic             sat_o
);

    if (TO_SM) begin : g_to_sm
        localparam logic [IN_W-1:0] MAG_MAX = IN_W'({(OUT_W-1){1'b1}});
        logic [IN_W-1:0] mag;
        logic            big;
        assign mag   = a_i[IN_W-1] ? -a_i : a_i;
        assign big   = mag > MAG_MAX;
        // A non-zero negative value always has a non-zero magnitude, so -0 cannot appear.
        assign b_o   = {a_i[IN_W-1], big ? MAG_MAX[OUT_W-2:0] : mag[OUT_W-2:0]};
        assign sat_o = big;
    end else begin : g_to_tc
        logic [OUT_W-1:0] ext;
        assign ext   = OUT_W'(a_i[IN_W-2:0]);
        assign b_o   = a_i[IN_W-1] ? -ext : ext;
        assign sat_o = 1'b0;
    end

endmodule

// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC engine: quadrant fold, one shared shift/add micro-rotation per clock, final gain multiply.
module cordic_iter_engine
    import cordic_pkg::*;
#(
    parameter int unsigned W    = 32,
    parameter int unsigned ITER = 16,
    parameter int unsigned GW   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [W-1:0] x_in,
    input  logic [W-1:0] y_in,
    input  logic [W-1:0] z_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] x_out,
    output logic [W-1:0] y_out,
    output logic [W-1:0] z_out,
    output logic         ovf
);

    localparam int unsigned   IW     = W + GW;
    localparam int unsigned   IXW    = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [IW-1:0] PI_2   = IW'(pi_2_fx(W - 3));
    localparam logic [KF-1:0] K_ITER = k_gain(ITER);

    logic [2:0]     state_q, state_d;
    mode_e          mode_q, mode_d;
    logic [IXW-1:0] i_q, i_d;
    logic [IW-1:0]  x_q, x_d, y_q, y_d, z_q, z_d;
    logic           in_ready_q, in_ready_d, out_valid_q, out_valid_d, ovf_q, ovf_d;
    logic [W-1:0]   x_out_q, x_out_d, y_out_q, y_out_d, z_out_q, z_out_d;

    logic [IW-1:0]  x_tc, y_tc, z_tc, x_sh, y_sh, atan_i;
    logic [W-1:0]   x_sm, y_sm, z_sm;
    logic           x_sat, y_sat, d_pos;
    logic [3:0]     unused_sat;
    logic [IW-1:0]  atan_tab [ITER];

    cordic_sm_conv #(.IN_W(W), .OUT_W(IW), .TO_SM(1'b0)) u_cx_in (.a_i(x_in), .b_o(x_tc), .sat_o(unused_sat[0]));
    cordic_sm_conv #(.IN_W(W), .OUT_W(IW), .TO_SM(1'b0)) u_cy_in (.a_i(y_in), .b_o(y_tc), .sat_o(unused_sat[1]));
    cordic_sm_conv #(.IN_W(W), .OUT_W(IW), .TO_SM(1'b0)) u_cz_in (.a_i(z_in), .b_o(z_tc), .sat_o(unused_sat[2]));
    cordic_sm_conv #(.IN_W(IW), .OUT_W(W), .TO_SM(1'b1)) u_cx_out (.a_i(x_q), .b_o(x_sm), .sat_o(x_sat));
    cordic_sm_conv #(.IN_W(IW), .OUT_W(W), .TO_SM(1'b1)) u_cy_out (.a_i(y_q), .b_o(y_sm), .sat_o(y_sat));
    cordic_sm_conv #(.IN_W(IW), .OUT_W(W), .TO_SM(1'b1)) u_cz_out (.a_i(z_q), .b_o(z_sm), .sat_o(unused_sat[3]));

    for (genvar g = 0; g < ITER; g++) begin : g_atan
        assign atan_tab[g] = IW'(atan_fx(W - 3, g));
    end

    // Single shared barrel shifter and angle lookup, both indexed by the iteration counter.
    assign x_sh   = IW'($signed(x_q) >>> i_q);
    assign y_sh   = IW'($signed(y_q) >>> i_q);
    assign atan_i = atan_tab[i_q];
    assign d_pos  = (mode_q == MODE_ROT) ? !z_q[IW-1] : y_q[IW-1];

    // Multiply by K on the magnitude so the discarded fraction truncates toward zero.
    function automatic logic [IW-1:0] gain_mul(logic [IW-1:0] v);
        logic [IW-1:0]    mag;
        logic [IW+KF-1:0] prod;
        logic [IW-1:0]    res;
        mag  = v[IW-1] ? -v : v;
        prod = (IW+KF)'(mag) * (IW+KF)'(K_ITER);
        res  = IW'(prod >> KF);
        return v[IW-1] ? -res : res;
    endfunction

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        i_d         = i_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        out_valid_d = out_valid_q;
        x_out_d     = x_out_q;
        y_out_d     = y_out_q;
        z_out_d     = z_out_q;
        ovf_d       = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    mode_d  = mode_e'(mode);
                    x_d     = x_tc;
                    y_d     = y_tc;
                    z_d     = z_tc;
                    state_d = S_PRE;
                end
            end
            S_PRE: begin
                if (mode_q == MODE_ROT) begin
                    if ($signed(z_q) > $signed(PI_2)) begin
                        x_d = -y_q;
                        y_d = x_q;
                        z_d = z_q - PI_2;
                    end else if ($signed(z_q) < -$signed(PI_2)) begin
                        x_d = y_q;
                        y_d = -x_q;
                        z_d = z_q + PI_2;
                    end
                end else if (x_q[IW-1]) begin
                    if (!y_q[IW-1]) begin
                        x_d = y_q;
                        y_d = -x_q;
                        z_d = z_q + PI_2;
                    end else begin
                        x_d = -y_q;
                        y_d = x_q;
                        z_d = z_q - PI_2;
                    end
                end
                i_d     = '0;
                state_d = S_ITER;
            end
            S_ITER: begin
                if (d_pos) begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atan_i;
                end else begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atan_i;
                end
                if (i_q == IXW'(ITER - 1)) state_d = S_GAIN;
                else                       i_d     = i_q + IXW'(1);
            end
            S_GAIN: begin
                x_d     = gain_mul(x_q);
                y_d     = gain_mul(y_q);
                state_d = S_DONE;
            end
            S_DONE: begin
                // First DONE cycle registers the result; afterwards hold until the consumer takes it.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    x_out_d     = x_sm;
                    y_out_d     = y_sm;
                    z_out_d     = z_sm;
                    ovf_d       = x_sat | y_sat;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mode_q      <= MODE_ROT;
            i_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            x_out_q     <= '0;
            y_out_q     <= '0;
            z_out_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            i_q         <= i_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            x_out_q     <= x_out_d;
            y_out_q     <= y_out_d;
            z_out_q     <= z_out_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign x_out     = x_out_q;
    assign y_out     = y_out_q;
    assign z_out     = z_out_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Directed bench for cordic_iter_engine: hand-computed vectors, handshake hold, busy-drop and mid-op reset.
module tb_cordic_iter_engine;

    localparam longint TOL_XY = 131072;      // 2^-13 in Q1.30
    localparam longint TOL_Z  = 65536;       // 2^-13 in Q2.29
    localparam longint ONE    = 1073741824;
    localparam longint COS30  = 929887697;
    localparam longint SIN30  = 536870912;
    localparam longint COS3   = -1062996349;
    localparam longint SIN3   = 151526455;
    localparam longint ATN43  = 497837829;
    localparam longint PI_Z   = 1686629713;
    localparam longint PI4_Z  = 421657428;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, mode, out_valid, out_ready, ovf;
    logic [31:0] x_in, y_in, z_in, x_out, y_out, z_out;
    int          total = 0;
    int          bad   = 0;
    int          lat;
    int          extra;

    cordic_iter_engine #(.W(32), .ITER(16), .GW(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .x_in(x_in), .y_in(y_in), .z_in(z_in), .out_valid(out_valid), .out_ready(out_ready),
        .x_out(x_out), .y_out(y_out), .z_out(z_out), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp, input longint tol);
        total++;
        if (got - exp > tol || exp - got > tol) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    function automatic longint sm2i(input logic [31:0] v);
        return v[31] ? -longint'(v[30:0]) : longint'(v[30:0]);
    endfunction

    task automatic start_op(input logic m, input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        int n = 0;
        while (!in_ready && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_before_op", longint'(in_ready), 1, 0);
        mode = m; x_in = x; y_in = y; z_in = z;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!out_valid && n < 100);
        if (!out_valid) chk("result_timeout", longint'(out_valid), 1, 0);
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_after_take", longint'(out_valid), 0, 0);
        chk("in_ready_after_take", longint'(in_ready), 1, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0;
        x_in = '0; y_in = '0; z_in = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_in_ready", longint'(in_ready), 1, 0);
        chk("rst_out_valid", longint'(out_valid), 0, 0);
        chk("rst_x_out", longint'(x_out), 0, 0);
        chk("rst_y_out", longint'(y_out), 0, 0);
        chk("rst_z_out", longint'(z_out), 0, 0);
        chk("rst_ovf", longint'(ovf), 0, 0);

        // Rotation by pi/6 with latency and output-hold checks.
        start_op(1'b0, 32'h4000_0000, 32'h0, 32'd281104894);
        wait_result(lat);
        chk("rot30_latency", longint'(lat), 19, 0);
        chk("rot30_x", sm2i(x_out), COS30, TOL_XY);
        chk("rot30_y", sm2i(y_out), SIN30, TOL_XY);
        chk("rot30_z", sm2i(z_out), 0, TOL_Z);
        chk("rot30_ovf", longint'(ovf), 0, 0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("hold_out_valid", longint'(out_valid), 1, 0);
            chk("hold_in_ready", longint'(in_ready), 0, 0);
            chk("hold_x", sm2i(x_out), COS30, TOL_XY);
        end
        take_result();

        // Rotation by 3.0 rad (quadrant fold) with a stray request while busy.
        start_op(1'b0, 32'h4000_0000, 32'h0, 32'h6000_0000);
        repeat (5) @(posedge clk);
        #1 mode = 1'b1; x_in = 32'h2000_0000; y_in = 32'h2000_0000; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        wait_result(lat);
        chk("rot3_x", sm2i(x_out), COS3, TOL_XY);
        chk("rot3_y", sm2i(y_out), SIN3, TOL_XY);
        chk("rot3_ovf", longint'(ovf), 0, 0);
        take_result();
        extra = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (out_valid) extra++;
        end
        chk("busy_request_dropped", longint'(extra), 0, 0);

        // Vectoring 0.6 + j0.8.
        start_op(1'b1, 32'd644245094, 32'd858993459, 32'h0);
        wait_result(lat);
        chk("vec34_latency", longint'(lat), 19, 0);
        chk("vec34_x", sm2i(x_out), ONE, TOL_XY);
        chk("vec34_y", sm2i(y_out), 0, TOL_XY);
        chk("vec34_z", sm2i(z_out), ATN43, TOL_Z);
        take_result();

        // Vectoring -1.0 + j0 folds through the second quadrant to +pi.
        start_op(1'b1, 32'hC000_0000, 32'h8000_0000, 32'h0);
        wait_result(lat);
        chk("vecneg_x", sm2i(x_out), ONE, TOL_XY);
        chk("vecneg_y", sm2i(y_out), 0, TOL_XY);
        chk("vecneg_z", sm2i(z_out), PI_Z, TOL_Z);
        chk("vecneg_ovf", longint'(ovf), 0, 0);
        take_result();

        // Vectoring 1.9 + j1.9: magnitude exceeds the output range.
        start_op(1'b1, 32'd2040109466, 32'd2040109466, 32'h0);
        wait_result(lat);
        chk("vecsat_x", longint'(x_out), 64'h7FFF_FFFF, 0);
        chk("vecsat_ovf", longint'(ovf), 1, 0);
        chk("vecsat_z", sm2i(z_out), PI4_Z, TOL_Z);
        chk("vecsat_y", sm2i(y_out), 0, TOL_XY);
        take_result();

        // Reset during iteration 8 aborts the operation and clears the held result.
        start_op(1'b0, 32'h4000_0000, 32'h0, 32'd281104894);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_out_valid", longint'(out_valid), 0, 0);
        chk("midrst_in_ready", longint'(in_ready), 1, 0);
        chk("midrst_x_out", longint'(x_out), 0, 0);
        chk("midrst_y_out", longint'(y_out), 0, 0);
        chk("midrst_z_out", longint'(z_out), 0, 0);
        chk("midrst_ovf", longint'(ovf), 0, 0);

        start_op(1'b0, 32'h4000_0000, 32'h0, 32'd281104894);
        wait_result(lat);
        chk("post_rst_latency", longint'(lat), 19, 0);
        chk("post_rst_x", sm2i(x_out), COS30, TOL_XY);
        chk("post_rst_y", sm2i(y_out), SIN30, TOL_XY);
        take_result();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
